// File: rtl/pc_sequencer_if.sv
// Bundle between the instruction decoder/top level and the program sequencer.
// The decoder side uses the master modport; pc_sequencer uses the slave modport.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             start;
  logic             halt;
  logic             jmp_en;
  logic             jmp_abs;
  logic [PC_W-1:0]  jmp_target;
  logic [7:0]       rel_off;
  logic             flags_wr_en;
  logic [2:0]       alu_flags;
  logic [PC_W-1:0]  pc;
  logic [2:0]       flags;
  logic             run;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;
  logic [1:0]       state;

  modport master (
    output start, halt, jmp_en, jmp_abs, jmp_target, rel_off, flags_wr_en, alu_flags,
    input  pc, flags, run, done, cycle_cnt, state
  );

  modport slave (
    input  start, halt, jmp_en, jmp_abs, jmp_target, rel_off, flags_wr_en, alu_flags,
    output pc, flags, run, done, cycle_cnt, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program sequencer: owns PC, {c,n,z} flags, the cycle counter and the
// IDLE/RUN/DONE run handshake for the 9-bit-instruction datapath.
module pc_sequencer #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  pc_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_next;
  logic [2:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PC_W-1:0]  rel_ext;

  // Handshake: start is a level request sampled in IDLE and DONE only; done
  // stays high in DONE until start is seen, and the following cycle is the
  // first RUN cycle fetching START_ADDR.
  assign rel_ext = {{(PC_W-8){bus.rel_off[7]}}, bus.rel_off};

  always_comb begin
    pc_next = pc_q + PC_W'(1);
    if (bus.jmp_en) begin
      if (bus.jmp_abs) pc_next = bus.jmp_target;
      else             pc_next = pc_q + rel_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= START_PC;
      flags_q <= 3'b000;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            pc_q  <= START_PC;
            cnt_q <= '0;
          end
        end
        RUN: begin
          if (bus.flags_wr_en) flags_q <= bus.alu_flags;
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
          // Halt wins over any jump decoded in the same instruction.
          if (bus.halt) state <= DONE;
          else          pc_q  <= pc_next;
        end
        DONE: begin
          if (bus.start) begin
            state   <= RUN;
            pc_q    <= START_PC;
            flags_q <= 3'b000;
            cnt_q   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.flags     = flags_q;
  assign bus.cycle_cnt = cnt_q;
  assign bus.run       = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.state     = state;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with an expected-value queue
// drained by an independent negedge monitor.
module tb_pc_sequencer;
  localparam int PC_W  = 10;
  localparam int CNT_W = 16;
  localparam int EXP_W = PC_W + 3 + 1 + 1 + CNT_W;

  logic clk;
  logic reset;

  pc_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  pc_sequencer #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  int               checks = 0;
  int               errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] exp_v;
      logic [EXP_W-1:0] act_v;
      string            nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {bus.pc, bus.flags, bus.run, bus.done, bus.cycle_cnt};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got pc=%h flags=%b run=%b done=%b cnt=%0d, expected pc=%h flags=%b run=%b done=%b cnt=%0d",
                 nm, act_v[EXP_W-1 -: PC_W], act_v[CNT_W+4 -: 3], act_v[CNT_W+1], act_v[CNT_W],
                 act_v[CNT_W-1:0], exp_v[EXP_W-1 -: PC_W], exp_v[CNT_W+4 -: 3], exp_v[CNT_W+1],
                 exp_v[CNT_W], exp_v[CNT_W-1:0]);
      end
    end
  end

  // driver: apply one cycle of inputs; expected values describe the state
  // after the next rising edge
  task automatic step(input logic rst, input logic st, input logic hlt, input logic je,
                      input logic ja, input logic [PC_W-1:0] tgt, input logic [7:0] off,
                      input logic fwe, input logic [2:0] alu, input logic chk,
                      input logic [PC_W-1:0] e_pc, input logic [2:0] e_fl, input logic e_run,
                      input logic e_done, input logic [CNT_W-1:0] e_cnt, input string nm);
    @(negedge clk);
    #1;
    reset           = rst;
    bus.start       = st;
    bus.halt        = hlt;
    bus.jmp_en      = je;
    bus.jmp_abs     = ja;
    bus.jmp_target  = tgt;
    bus.rel_off     = off;
    bus.flags_wr_en = fwe;
    bus.alu_flags   = alu;
    if (chk) begin
      exp_q.push_back({e_pc, e_fl, e_run, e_done, e_cnt});
      name_q.push_back(nm);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.halt        = 1'b0;
    bus.jmp_en      = 1'b0;
    bus.jmp_abs     = 1'b0;
    bus.jmp_target  = '0;
    bus.rel_off     = '0;
    bus.flags_wr_en = 1'b0;
    bus.alu_flags   = 3'b000;

    //   rst st hlt je ja tgt     off    fwe alu    chk  pc      fl     run done cnt
    step(1, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 0, 0, 16'd0,  "reset");
    step(1, 1, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 0, 0, 16'd0,  "start_in_reset");
    step(0, 1, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 1, 0, 16'd0,  "start_latency");
    step(0, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h001, 3'b000, 1, 0, 16'd1,  "seq_1");
    step(0, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h002, 3'b000, 1, 0, 16'd2,  "seq_2");
    step(0, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h003, 3'b000, 1, 0, 16'd3,  "seq_3");
    step(0, 0, 0, 0, 0, 10'h000, 8'h00, 1, 3'b101, 1, 10'h004, 3'b101, 1, 0, 16'd4,  "flag_write");
    step(0, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b010, 1, 10'h005, 3'b101, 1, 0, 16'd5,  "flag_hold");
    step(0, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h006, 3'b101, 1, 0, 16'd6,  "seq_6");
    step(0, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h007, 3'b101, 1, 0, 16'd7,  "seq_7");
    step(0, 0, 0, 1, 1, 10'h155, 8'h00, 0, 3'b000, 1, 10'h155, 3'b101, 1, 0, 16'd8,  "jmp_abs");
    step(0, 0, 0, 1, 0, 10'h000, 8'hFC, 0, 3'b000, 1, 10'h151, 3'b101, 1, 0, 16'd9,  "jmp_rel_neg");
    step(0, 0, 0, 1, 1, 10'h3FF, 8'h00, 0, 3'b000, 1, 10'h3FF, 3'b101, 1, 0, 16'd10, "jmp_to_top");
    step(0, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b101, 1, 0, 16'd11, "pc_wrap");
    step(0, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h001, 3'b101, 1, 0, 16'd12, "seq_after_wrap1");
    step(0, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h002, 3'b101, 1, 0, 16'd13, "seq_after_wrap2");
    step(0, 0, 0, 1, 0, 10'h000, 8'h80, 0, 3'b000, 1, 10'h382, 3'b101, 1, 0, 16'd14, "jmp_rel_wrap");
    step(0, 0, 0, 1, 1, 10'h009, 8'h00, 0, 3'b000, 1, 10'h009, 3'b101, 1, 0, 16'd15, "jmp_to_9");
    step(0, 0, 1, 1, 1, 10'h055, 8'h00, 1, 3'b011, 1, 10'h009, 3'b011, 0, 1, 16'd16, "halt_over_jmp");
    step(0, 0, 1, 1, 1, 10'h055, 8'h07, 1, 3'b110, 1, 10'h009, 3'b011, 0, 1, 16'd16, "done_hold");
    step(0, 1, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 1, 0, 16'd0,  "restart_from_done");
    step(0, 1, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h001, 3'b000, 1, 0, 16'd1,  "start_ignored_run");
    step(0, 0, 0, 1, 1, 10'h020, 8'h00, 1, 3'b110, 1, 10'h020, 3'b110, 1, 0, 16'd2,  "jmp_to_20");
    step(1, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 0, 0, 16'd0,  "reset_mid_run");
    step(0, 0, 1, 1, 1, 10'h123, 8'h00, 1, 3'b111, 1, 10'h000, 3'b000, 0, 0, 16'd0,  "idle_hold");
    step(0, 1, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 1, 0, 16'd0,  "start_from_idle");
    step(0, 1, 1, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 0, 1, 16'd1,  "halt_start_held");
    step(0, 1, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 1, 0, 16'd0,  "auto_restart");

    // saturation: rel_off=0 parks the PC so the counter can run to its ceiling
    for (int i = 0; i < 65534; i++)
      step(0, 0, 0, 1, 0, 10'h000, 8'h00, 0, 3'b000, 0, 10'h000, 3'b000, 0, 0, 16'd0, "");
    step(0, 0, 0, 1, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 1, 0, 16'hFFFF, "cnt_reach_max");
    step(0, 0, 0, 1, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 1, 0, 16'hFFFF, "cnt_saturate");
    step(0, 0, 1, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 0, 1, 16'hFFFF, "halt_saturated");
    step(0, 0, 0, 0, 0, 10'h000, 8'h00, 0, 3'b000, 1, 10'h000, 3'b000, 0, 1, 16'hFFFF, "done_saturated");

    // bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
